// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Read/write request channel pair between a bus initiator (IFU, memory
//   stage, testbench) and mem_responder.
//   Read:  arvalid/arready/araddr request, rvalid/rready/rdata/rresp response.
//   Write: awvalid/awready/awaddr + wvalid/wready/wdata/wstrb request,
//          bvalid/bready/bresp response.
//   Response codes: 2'b00 OKAY, 2'b10 SLVERR.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output arvalid, araddr, rready,
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Word-addressed on-chip memory answering one read or one write at a time
//   with a fixed access latency of LATENCY wait cycles (0..15).
//   Ports:
//     clk  - clock, all state changes on posedge
//     rst  - synchronous active-low reset
//     bus  - mem_responder_if slave modport (read and write channels)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a request; reads win over a simultaneous write
//   RWAIT | read accepted, wait counter running
//   RRESP | read data/response held until rvalid & rready
//   WWAIT | write accepted, wait counter running
//   WRESP | write committed, response held until bvalid & bready
module mem_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int                  IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;
  localparam logic [3:0]          LAT_LOAD = 4'(LATENCY);
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RWAIT,
    RRESP,
    WWAIT,
    WRESP
  } state_t;

  state_t                  state;
  state_t                  stateNext;
  logic [3:0]              waitCnt;

  logic [ADDR_WIDTH-1:0]   addrQ;
  logic [DATA_WIDTH-1:0]   wdataQ;
  logic [3:0]              wstrbQ;

  logic [DATA_WIDTH-1:0]   rdataQ;
  logic [1:0]              rrespQ;
  logic [1:0]              brespQ;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic                    rdAccept;
  logic                    wrAccept;
  logic                    waitDone;
  logic                    enterRresp;
  logic                    enterWresp;

  logic [ADDR_WIDTH-1:0]   curAddr;
  logic [DATA_WIDTH-1:0]   curWdata;
  logic [3:0]              curWstrb;
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    inRange;
  logic [IDX_W-1:0]        idx;

  assign rdAccept = (state == IDLE) && bus.arvalid;
  assign wrAccept = (state == IDLE) && bus.awvalid && bus.wvalid && !bus.arvalid;

  // Terminal count is 1: the wait state is left on the edge where the
  // counter would otherwise tick from 1 to 0.
  assign waitDone = (waitCnt <= 4'd1);

  // With zero latency the response is formed on the acceptance edge itself,
  // so the request fields must bypass the capture registers.
  always_comb begin
    curAddr  = addrQ;
    curWdata = wdataQ;
    curWstrb = wstrbQ;
    if (state == IDLE) begin
      curAddr  = bus.arvalid ? bus.araddr : bus.awaddr;
      curWdata = bus.wdata;
      curWstrb = bus.wstrb;
    end
  end

  // Unsigned window check; the extra top bit keeps BASE_ADDR + span from
  // wrapping when the window sits at the top of the address space.
  assign offset  = curAddr - BASE_ADDR;
  assign inRange = (curAddr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign idx     = offset[IDX_W+1:2];

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (rdAccept) begin
          stateNext = (LATENCY == 0) ? RRESP : RWAIT;
        end else if (wrAccept) begin
          stateNext = (LATENCY == 0) ? WRESP : WWAIT;
        end
      end
      RWAIT: begin
        if (waitDone) stateNext = RRESP;
      end
      RRESP: begin
        if (bus.rready) stateNext = IDLE;
      end
      WWAIT: begin
        if (waitDone) stateNext = WRESP;
      end
      WRESP: begin
        if (bus.bready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign enterRresp = (stateNext == RRESP) && (state != RRESP);
  assign enterWresp = (stateNext == WRESP) && (state != WRESP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
      rdataQ  <= '0;
      rrespQ  <= RESP_OKAY;
      brespQ  <= RESP_OKAY;
    end else begin
      state <= stateNext;

      if (rdAccept || wrAccept) begin
        waitCnt <= LAT_LOAD;
      end else if ((state == RWAIT || state == WWAIT) && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end

      if (enterRresp) begin
        rdataQ <= inRange ? mem[idx] : '0;
        rrespQ <= inRange ? RESP_OKAY : RESP_SLVERR;
      end

      if (enterWresp) begin
        brespQ <= inRange ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Request capture needs no reset: the fields are only consumed after a
  // fresh acceptance has overwritten them.
  always_ff @(posedge clk) begin
    if (rdAccept) begin
      addrQ <= bus.araddr;
    end else if (wrAccept) begin
      addrQ  <= bus.awaddr;
      wdataQ <= bus.wdata;
      wstrbQ <= bus.wstrb;
    end
  end

  // The array is not reset so contents survive rst. The rst term drops a
  // write whose commit edge coincides with reset.
  always_ff @(posedge clk) begin
    if (rst && enterWresp && inRange) begin
      for (int b = 0; b < 4; b++) begin
        if (curWstrb[b]) mem[idx][8*b +: 8] <= curWdata[8*b +: 8];
      end
    end
  end

  assign bus.arready = (state == IDLE);
  assign bus.awready = wrAccept;
  assign bus.wready  = wrAccept;
  assign bus.rvalid  = (state == RRESP);
  assign bus.rdata   = rdataQ;
  assign bus.rresp   = rrespQ;
  assign bus.bvalid  = (state == WRESP);
  assign bus.bresp   = brespQ;

  a_rHold: assert property (@(posedge clk) disable iff (!rst)
    (bus.rvalid && !bus.rready) |=> (bus.rvalid && $stable(bus.rdata) && $stable(bus.rresp)));

  a_bHold: assert property (@(posedge clk) disable iff (!rst)
    (bus.bvalid && !bus.bready) |=> (bus.bvalid && $stable(bus.bresp)));

  a_oneResp: assert property (@(posedge clk) disable iff (!rst)
    !(bus.rvalid && bus.bvalid));

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives two responders (LATENCY 1 and LATENCY 4) through a shared set of
//   request signals steered by sel, and checks them against a word-indexed
//   reference memory kept as an associative array.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst4, sel;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;

  mem_responder_if #(.ADDR_WIDTH(32)) bus1 ();
  mem_responder_if #(.ADDR_WIDTH(32)) bus4 ();

  assign bus1.arvalid = arvalid & ~sel;
  assign bus1.araddr  = araddr;
  assign bus1.rready  = rready & ~sel;
  assign bus1.awvalid = awvalid & ~sel;
  assign bus1.awaddr  = awaddr;
  assign bus1.wvalid  = wvalid & ~sel;
  assign bus1.wdata   = wdata;
  assign bus1.wstrb   = wstrb;
  assign bus1.bready  = bready & ~sel;

  assign bus4.arvalid = arvalid & sel;
  assign bus4.araddr  = araddr;
  assign bus4.rready  = rready & sel;
  assign bus4.awvalid = awvalid & sel;
  assign bus4.awaddr  = awaddr;
  assign bus4.wvalid  = wvalid & sel;
  assign bus4.wdata   = wdata;
  assign bus4.wstrb   = wstrb;
  assign bus4.bready  = bready & sel;

  mem_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  mem_responder #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  logic        arreadyS, awreadyS, wreadyS, rvalidS, bvalidS;
  logic [31:0] rdataS;
  logic [1:0]  rrespS, brespS;

  assign arreadyS = sel ? bus4.arready : bus1.arready;
  assign awreadyS = sel ? bus4.awready : bus1.awready;
  assign wreadyS  = sel ? bus4.wready  : bus1.wready;
  assign rvalidS  = sel ? bus4.rvalid  : bus1.rvalid;
  assign bvalidS  = sel ? bus4.bvalid  : bus1.bvalid;
  assign rdataS   = sel ? bus4.rdata   : bus1.rdata;
  assign rrespS   = sel ? bus4.rresp   : bus1.rresp;
  assign brespS   = sel ? bus4.bresp   : bus1.bresp;

  int checks = 0;
  int errors = 0;

  // Reference memory, keyed by {which DUT, word index}.
  logic [31:0] model [int];

  function automatic bit in_range(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_1000);
  endfunction

  function automatic int key(input logic s, input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'h8000_0000) >> 2;
    return (s ? 4096 : 0) + int'(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic int exp_lat();
    return sel ? 4 : 1;
  endfunction

  // Applies the write rule to the model and returns the expected bresp.
  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int k;
    if (!in_range(a)) return 2'b10;
    k = key(sel, a);
    model[k] = merge(model.exists(k) ? model[k] : 32'h0, d, s);
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int k;
    if (!in_range(a)) return 32'h0;
    k = key(sel, a);
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus helpers: start from IDLE, leave the DUT back in IDLE. lat is the
  // number of cycles between the acceptance edge's following cycle and rvalid.
  task automatic do_read(input logic [31:0] addr, input int rdyDelay,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int k;
    arvalid = 1'b1;
    araddr  = addr;
    rready  = 1'b0;
    tick();
    arvalid = 1'b0;
    k = 1;
    while (!rvalidS && k < 64) begin
      tick();
      k++;
    end
    lat  = k - 1;
    data = rdataS;
    resp = rrespS;
    for (int i = 0; i < rdyDelay; i++) tick();
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int rdyDelay,
                          output logic [1:0] resp, output int lat);
    int k;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    bready  = 1'b0;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    k = 1;
    while (!bvalidS && k < 64) begin
      tick();
      k++;
    end
    lat  = k - 1;
    resp = brespS;
    for (int i = 0; i < rdyDelay; i++) tick();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst1 = 1'b0;
    rst4 = 1'b0;
    arvalid = 1'b1;
    araddr  = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus1.arready !== 1'b1 || bus4.arready !== 1'b1) begin
        errors++;
        $display("FAIL reset_arready: got %b/%b expected 1/1", bus1.arready, bus4.arready);
      end
      checks++;
      if ({bus1.rvalid, bus1.bvalid, bus4.rvalid, bus4.bvalid} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_valids: got %b expected 0000",
                 {bus1.rvalid, bus1.bvalid, bus4.rvalid, bus4.bvalid});
      end
      checks++;
      if (bus1.rdata !== 32'h0 || bus4.rdata !== 32'h0 || bus1.rresp !== 2'b00 || bus1.bresp !== 2'b00) begin
        errors++;
        $display("FAIL reset_data: got rdata %h/%h rresp %b bresp %b expected zeros",
                 bus1.rdata, bus4.rdata, bus1.rresp, bus1.bresp);
      end
    end
    arvalid = 1'b0;
    rst1 = 1'b1;
    rst4 = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    logic [1:0]  r, er;
    int          lat;
    sel = 1'b0;
    er = model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, r, lat);
    checks++;
    if (lat !== exp_lat() || r !== er) begin
      errors++;
      $display("FAIL wr_basic: got lat %0d bresp %b expected lat %0d bresp %b", lat, r, exp_lat(), er);
    end
    do_read(32'h8000_0010, 0, d, r, lat);
    checks++;
    if (lat !== exp_lat() || r !== 2'b00 || d !== model_read(32'h8000_0010)) begin
      errors++;
      $display("FAIL rd_basic: got lat %0d rdata %h rresp %b expected lat %0d rdata %h rresp 00",
               lat, d, r, exp_lat(), model_read(32'h8000_0010));
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r, er;
    int          lat;
    sel = 1'b0;
    er = model_write(32'h8000_0010, 32'h1122_3344, 4'hF);
    do_write(32'h8000_0010, 32'h1122_3344, 4'hF, 0, r, lat);
    er = model_write(32'h8000_0010, 32'hAABB_CCDD, 4'b0101);
    do_write(32'h8000_0010, 32'hAABB_CCDD, 4'b0101, 0, r, lat);
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL strobe_bresp: got %b expected %b", r, er);
    end
    do_read(32'h8000_0010, 0, d, r, lat);
    checks++;
    if (d !== model_read(32'h8000_0010) || d !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL strobe_data: got %h expected %h", d, model_read(32'h8000_0010));
    end
    er = model_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0, r, lat);
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL strobe0_bresp: got %b expected %b", r, er);
    end
    // Low address bits are ignored.
    do_read(32'h8000_0013, 0, d, r, lat);
    checks++;
    if (d !== model_read(32'h8000_0010) || r !== 2'b00) begin
      errors++;
      $display("FAIL strobe0_data: got %h/%b expected %h/00", d, r, model_read(32'h8000_0010));
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0]  r, er;
    int          lat;
    sel = 1'b0;
    er = model_write(32'h8000_0FFC, 32'hCAFE_0FFC, 4'hF);
    do_write(32'h8000_0FFC, 32'hCAFE_0FFC, 4'hF, 0, r, lat);
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL oor_last_word_bresp: got %b expected %b", r, er);
    end
    do_read(32'h8000_1000, 0, d, r, lat);
    checks++;
    if (r !== 2'b10 || d !== model_read(32'h8000_1000) || lat !== exp_lat()) begin
      errors++;
      $display("FAIL oor_read: got rresp %b rdata %h lat %0d expected 10 %h %0d",
               r, d, lat, model_read(32'h8000_1000), exp_lat());
    end
    er = model_write(32'h7FFF_FFFC, 32'h0BAD_0BAD, 4'hF);
    do_write(32'h7FFF_FFFC, 32'h0BAD_0BAD, 4'hF, 0, r, lat);
    checks++;
    if (r !== er || r !== 2'b10) begin
      errors++;
      $display("FAIL oor_write: got bresp %b expected %b", r, er);
    end
    do_read(32'h8000_0FFC, 0, d, r, lat);
    checks++;
    if (r !== 2'b00 || d !== model_read(32'h8000_0FFC)) begin
      errors++;
      $display("FAIL oor_word1023: got %h/%b expected %h/00", d, r, model_read(32'h8000_0FFC));
    end
  endtask

  task automatic test_backpressure();
    int          k;
    logic [31:0] expD;
    sel = 1'b0;
    expD = model_read(32'h8000_0010);
    arvalid = 1'b1;
    araddr  = 32'h8000_0010;
    rready  = 1'b0;
    tick();
    arvalid = 1'b0;
    k = 0;
    while (!rvalidS && k < 64) begin
      tick();
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalidS !== 1'b1 || rdataS !== expD || rrespS !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rvalid %b rdata %h rresp %b expected 1 %h 00",
                 i, rvalidS, rdataS, rrespS, expD);
      end
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if (rvalidS !== 1'b0 || arreadyS !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rvalid %b arready %b expected 0 1", rvalidS, arreadyS);
    end
  endtask

  task automatic test_priority();
    int          k;
    logic [31:0] oldD, d;
    logic [1:0]  er, r;
    int          lat;
    sel = 1'b0;
    oldD = model_read(32'h8000_0010);
    arvalid = 1'b1;
    araddr  = 32'h8000_0010;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    awaddr  = 32'h8000_0010;
    wdata   = 32'h5A5A_A5A5;
    wstrb   = 4'hF;
    rready  = 1'b0;
    bready  = 1'b1;
    #1;
    checks++;
    if (arreadyS !== 1'b1 || awreadyS !== 1'b0 || wreadyS !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle: got arready %b awready %b wready %b expected 1 0 0",
               arreadyS, awreadyS, wreadyS);
    end
    tick();
    arvalid = 1'b0;
    k = 0;
    while (!rvalidS && k < 64) begin
      checks++;
      if (awreadyS !== 1'b0) begin
        errors++;
        $display("FAIL prio_busy_awready: got %b expected 0", awreadyS);
      end
      tick();
      k++;
    end
    checks++;
    if (rvalidS !== 1'b1 || rdataS !== oldD) begin
      errors++;
      $display("FAIL prio_read_first: got rvalid %b rdata %h expected 1 %h", rvalidS, rdataS, oldD);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if (arreadyS !== 1'b1 || awreadyS !== 1'b1 || wreadyS !== 1'b1 || rvalidS !== 1'b0) begin
      errors++;
      $display("FAIL prio_write_next: got arready %b awready %b wready %b rvalid %b expected 1 1 1 0",
               arreadyS, awreadyS, wreadyS, rvalidS);
    end
    er = model_write(32'h8000_0010, 32'h5A5A_A5A5, 4'hF);
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    k = 1;
    while (!bvalidS && k < 64) begin
      tick();
      k++;
    end
    checks++;
    if (k - 1 !== exp_lat() || brespS !== er) begin
      errors++;
      $display("FAIL prio_write_resp: got lat %0d bresp %b expected %0d %b", k - 1, brespS, exp_lat(), er);
    end
    tick();
    bready = 1'b0;
    do_read(32'h8000_0010, 0, d, r, lat);
    checks++;
    if (d !== model_read(32'h8000_0010)) begin
      errors++;
      $display("FAIL prio_raw: got %h expected %h", d, model_read(32'h8000_0010));
    end
  endtask

  task automatic test_reset_mid_resp();
    int k;
    sel = 1'b0;
    arvalid = 1'b1;
    araddr  = 32'h8000_0010;
    rready  = 1'b0;
    tick();
    arvalid = 1'b0;
    k = 0;
    while (!rvalidS && k < 64) begin
      tick();
      k++;
    end
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    checks++;
    if (rvalidS !== 1'b0 || rdataS !== 32'h0 || arreadyS !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_resp: got rvalid %b rdata %h arready %b expected 0 0 1",
               rvalidS, rdataS, arreadyS);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    logic [1:0]  r, er;
    int          lat;
    bit          sawB;
    sel = 1'b1;
    er = model_write(32'h8000_0020, 32'h0BAD_F00D, 4'hF);
    do_write(32'h8000_0020, 32'h0BAD_F00D, 4'hF, 0, r, lat);
    checks++;
    if (lat !== exp_lat() || r !== er) begin
      errors++;
      $display("FAIL lat4_write: got lat %0d bresp %b expected %0d %b", lat, r, exp_lat(), er);
    end
    awvalid = 1'b1;
    wvalid  = 1'b1;
    awaddr  = 32'h8000_0020;
    wdata   = 32'h1234_5678;
    wstrb   = 4'hF;
    bready  = 1'b0;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    tick();
    rst4 = 1'b0;
    tick();
    rst4 = 1'b1;
    sawB = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bvalidS) sawB = 1'b1;
      tick();
    end
    checks++;
    if (sawB !== 1'b0 || arreadyS !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_write_bvalid: got bvalid seen %b arready %b expected 0 1", sawB, arreadyS);
    end
    do_read(32'h8000_0020, 0, d, r, lat);
    checks++;
    if (d !== model_read(32'h8000_0020) || r !== 2'b00 || lat !== exp_lat()) begin
      errors++;
      $display("FAIL rst_mid_write_data: got %h/%b lat %0d expected %h/00 lat %0d",
               d, r, lat, model_read(32'h8000_0020), exp_lat());
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, dw, expD;
    logic [3:0]  s;
    logic [1:0]  r, er;
    int          lat;
    for (int side = 0; side < 2; side++) begin
      sel = side[0];
      for (int i = 0; i < 8; i++) begin
        dw = $urandom;
        er = model_write(32'h8000_0000 + 32'(i * 4), dw, 4'hF);
        do_write(32'h8000_0000 + 32'(i * 4), dw, 4'hF, 0, r, lat);
      end
    end
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) == 1) ? 32'h8000_1000 + 32'($urandom_range(0, 15) * 4)
                                        : 32'h7FFF_FFC0 + 32'($urandom_range(0, 15) * 4);
      else
        a = 32'h8000_0000 + 32'($urandom_range(0, 7) * 4);
      a = a | 32'($urandom_range(0, 3));
      checks++;
      if (arreadyS !== 1'b1) begin
        errors++;
        $display("FAIL rand_idle[%0d]: got arready %b expected 1", n, arreadyS);
      end
      if ($urandom_range(0, 1) == 1) begin
        dw = $urandom;
        s  = 4'($urandom_range(0, 15));
        er = model_write(a, dw, s);
        do_write(a, dw, s, $urandom_range(0, 3), r, lat);
        checks++;
        if (r !== er || lat !== exp_lat()) begin
          errors++;
          $display("FAIL rand_write[%0d]: addr %h got bresp %b lat %0d expected %b %0d",
                   n, a, r, lat, er, exp_lat());
        end
      end else begin
        expD = model_read(a);
        do_read(a, $urandom_range(0, 3), d, r, lat);
        checks++;
        if (d !== expD || r !== (in_range(a) ? 2'b00 : 2'b10) || lat !== exp_lat()) begin
          errors++;
          $display("FAIL rand_read[%0d]: addr %h got %h/%b lat %0d expected %h/%b %0d",
                   n, a, d, r, lat, expD, in_range(a) ? 2'b00 : 2'b10, exp_lat());
        end
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
  endtask

  initial begin
    sel = 1'b0;
    rst1 = 1'b0;
    rst4 = 1'b0;
    arvalid = 1'b0;
    rready = 1'b0;
    awvalid = 1'b0;
    wvalid = 1'b0;
    bready = 1'b0;
    araddr = '0;
    awaddr = '0;
    wdata = '0;
    wstrb = '0;

    test_reset();
    test_write_read();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_priority();
    test_reset_mid_resp();
    test_reset_mid_write();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
